// File: rtl/ws2812_stream_decoder_if.sv
// Bundles the decoder's stream input and its frame/forwarding outputs.
//
// Handshake: there is no back-pressure. data_rdy is a single-cycle strobe
// that marks the cycle in which data first holds a newly latched frame, and
// data stays stable until the next strobe. frame_err is a single-cycle strobe
// that never coincides with data_rdy. din and dout are raw NRZ line levels.
interface ws2812_stream_decoder_if #(
    parameter int W = 192
);
    logic         din;
    logic [W-1:0] data;
    logic         data_rdy;
    logic         frame_err;
    logic         dout;
    logic [1:0]   dbg_state;

    // Stream source / frame consumer side
    modport master (
        output din,
        input  data, data_rdy, frame_err, dout, dbg_state
    );

    // Decoder side
    modport slave (
        input  din,
        output data, data_rdy, frame_err, dout, dbg_state
    );
endinterface

// File: rtl/ws2812_stream_decoder.sv
// WS2812-style NRZ stream decoder: classifies high pulses by width, assembles
// LEDS*BITS_PER_LED bits, latches the frame on a long low gap and forwards any
// surplus pulses on dout like the next LED in a chain.
module ws2812_stream_decoder #(
    parameter int LEDS         = 8,
    parameter int BITS_PER_LED = 24,
    parameter int T_THRESH     = 30,
    parameter int T_HIGH_MAX   = 100,
    parameter int T_RESET      = 2500
) (
    input  logic                    clk,
    input  logic                    reset,
    ws2812_stream_decoder_if.slave  bus
);
    localparam int N    = LEDS * BITS_PER_LED;
    localparam int CMAX = (T_RESET > T_HIGH_MAX) ? T_RESET : T_HIGH_MAX;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(N + 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            din_s_q;
    logic [CW-1:0]   low_cnt_q;
    logic [CW-1:0]   high_cnt_q;
    logic [BW-1:0]   bit_cnt_q;
    logic [N-1:0]    shift_q;
    logic [N-1:0]    data_q;
    logic            data_rdy_q;
    logic            frame_err_q;
    logic            fwd_q;
    logic            fwd_d;
    logic            dout_q;

    logic            hi_err;
    logic            lo_end;
    logic            sync_end;
    logic            rise_full;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Event decodes: each fires in the cycle the T_* limit is reached
    assign hi_err    = (state_q == HIGH) &&  din_s_q && (high_cnt_q == CW'(T_HIGH_MAX - 1));
    assign lo_end    = (state_q == LOW)  && !din_s_q && (low_cnt_q  == CW'(T_RESET - 1));
    assign sync_end  = (state_q == SYNC) && !din_s_q && (low_cnt_q  == CW'(T_RESET - 1));
    assign rise_full = (state_q == LOW)  &&  din_s_q && (bit_cnt_q  == BW'(N));

    // Forward enable: set on a rising edge once the frame is full, cleared by latch or error
    always_comb begin
        fwd_d = fwd_q;
        if (hi_err || lo_end) begin
            fwd_d = 1'b0;
        end else if (rise_full) begin
            fwd_d = 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous line input
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            din_s_q <= 1'b0;
        end else begin
            sync1_q <= bus.din;
            din_s_q <= sync1_q;
        end
    end

    // Decoder FSM with registered frame, strobes and forwarded line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            data_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            fwd_q       <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            data_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            fwd_q       <= fwd_d;
            dout_q      <= fwd_d & din_s_q;
            case (state_q)
                SYNC: begin
                    // Wait for a full reset gap so we never join mid-frame
                    if (din_s_q) begin
                        low_cnt_q <= '0;
                    end else if (sync_end) begin
                        low_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        low_cnt_q <= sat_inc(low_cnt_q);
                    end
                end
                IDLE: begin
                    if (din_s_q) begin
                        high_cnt_q <= CW'(1);
                        state_q    <= HIGH;
                    end
                end
                HIGH: begin
                    if (din_s_q) begin
                        if (hi_err) begin
                            frame_err_q <= 1'b1;
                            shift_q     <= '0;
                            bit_cnt_q   <= '0;
                            high_cnt_q  <= '0;
                            low_cnt_q   <= '0;
                            state_q     <= SYNC;
                        end else begin
                            high_cnt_q <= sat_inc(high_cnt_q);
                        end
                    end else begin
                        // Falling edge: the pulse width decides the bit
                        low_cnt_q <= CW'(1);
                        state_q   <= LOW;
                        if (bit_cnt_q < BW'(N)) begin
                            shift_q   <= {shift_q[N-2:0], (high_cnt_q >= CW'(T_THRESH))};
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                LOW: begin
                    if (din_s_q) begin
                        high_cnt_q <= CW'(1);
                        state_q    <= HIGH;
                    end else if (lo_end) begin
                        if (bit_cnt_q == BW'(N)) begin
                            data_q     <= shift_q;
                            data_rdy_q <= 1'b1;
                        end else if (bit_cnt_q != '0) begin
                            frame_err_q <= 1'b1;
                        end
                        bit_cnt_q <= '0;
                        low_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        low_cnt_q <= sat_inc(low_cnt_q);
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.data_rdy  = data_rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.dout      = dout_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ws2812_stream_decoder.sv
// Bench for ws2812_stream_decoder: directed scenarios plus random frames, all
// scored against a run-length model of the line protocol.
module tb_ws2812_stream_decoder;
    localparam int LEDS   = 1;
    localparam int BPL    = 8;
    localparam int N      = LEDS * BPL;
    localparam int THRESH = 4;
    localparam int HMAX   = 16;
    localparam int TRST   = 20;

    typedef struct {
        int start;
        int width;
    } pulse_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_stream_decoder_if #(.W(N)) bus ();

    ws2812_stream_decoder #(
        .LEDS(LEDS), .BITS_PER_LED(BPL), .T_THRESH(THRESH),
        .T_HIGH_MAX(HMAX), .T_RESET(TRST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [N-1:0] exp_q[$];
    pulse_t     exp_dout_q[$];
    logic [N-1:0] rdy_hist[$];
    int         err_exp = 0;
    int         exp_dout_cnt = 0;
    int         rdy_seen = 0;
    int         err_seen = 0;
    int         dout_cnt = 0;
    int         dout_pulses = 0;
    bit         dout_on = 0;
    int         dout_start = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on whole line runs (level, length): a pulse becomes a bit, a low
    // stretch of TRST cycles ends a frame, an over-long high is an error.
    bit  m_synced = 0;
    bit  m_fwd = 0;
    int  m_acc = 0;
    bit  m_bits[$];

    function automatic void model_reset();
        m_synced = 0;
        m_fwd    = 0;
        m_acc    = 0;
        m_bits.delete();
    endfunction

    function automatic void model_run(input bit level, input int len, input int start);
        int           prev;
        int           w;
        logic [N-1:0] v;
        if (level) begin
            m_acc = 0;
            if (m_synced) begin
                if (m_bits.size() == N) m_fwd = 1;
                if (m_fwd) begin
                    w = (len >= HMAX) ? HMAX - 1 : len;
                    exp_dout_q.push_back('{start + 3, w});
                    exp_dout_cnt += w;
                end
                if (len >= HMAX) begin
                    err_exp++;
                    m_bits.delete();
                    m_fwd    = 0;
                    m_synced = 0;
                end else if (m_bits.size() < N) begin
                    m_bits.push_back(len >= THRESH);
                end
            end
        end else begin
            prev  = m_acc;
            m_acc = m_acc + len;
            if (prev < TRST && m_acc >= TRST) begin
                if (!m_synced) begin
                    m_synced = 1;
                end else begin
                    if (m_bits.size() == N) begin
                        v = '0;
                        foreach (m_bits[i]) v = {v[N-2:0], m_bits[i]};
                        exp_q.push_back(v);
                    end else if (m_bits.size() > 0) begin
                        err_exp++;
                    end
                    m_bits.delete();
                    m_fwd = 0;
                end
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_run(input bit level, input int len);
        bus.din = level;
        model_run(level, len, cyc);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input int hi, input int lo);
        drive_run(1'b1, hi);
        drive_run(1'b0, lo);
    endtask

    // Standard widths: '1' = 6 high / 4 low, '0' = 2 high / 8 low; MSB first
    task automatic send_bits(input logic [15:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (v[i]) send_bit(1'b1, 6, 4);
            else      send_bit(1'b0, 2, 8);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.din = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 32'(bus.data), 32'h0);
        chk("rst_rdy", 32'(bus.data_rdy), 32'h0);
        chk("rst_err", 32'(bus.frame_err), 32'h0);
        chk("rst_dout", 32'(bus.dout), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            dout_on = 0;
        end else begin
            if (bus.data_rdy || bus.frame_err)
                chk("rdy_err_excl", 32'(bus.data_rdy && bus.frame_err), 32'h0);
            if (bus.data_rdy) begin
                rdy_seen++;
                rdy_hist.push_back(bus.data);
                chk("rdy_has_exp", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) chk("data", 32'(bus.data), 32'(exp_q.pop_front()));
            end
            if (bus.frame_err) err_seen++;
            if (bus.dout) dout_cnt++;
            if (bus.dout && !dout_on) begin
                dout_on    = 1;
                dout_start = cyc;
            end else if (!bus.dout && dout_on) begin
                pulse_t e;
                dout_on = 0;
                dout_pulses++;
                chk("dout_has_exp", 32'(exp_dout_q.size() > 0), 32'h1);
                if (exp_dout_q.size() > 0) begin
                    e = exp_dout_q.pop_front();
                    chk("dout_start", 32'(dout_start), 32'(e.start));
                    chk("dout_width", 32'(cyc - dout_start), 32'(e.width));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int hi6[8] = '{4, 3, 4, 4, 3, 3, 4, 3};
    int lo6[8] = '{5, 5, 5, 19, 5, 5, 5, 20};

    initial begin
        bus.din = 1'b0;
        model_reset();
        do_reset();
        drive_run(1'b0, 20);

        // 1: clean frame 0xA5
        send_bits(16'hA5, 8);
        drive_run(1'b0, 26);
        chk("t1_data", 32'(bus.data), 32'hA5);
        chk("t1_rdy_cnt", 32'(rdy_seen), 32'd1);
        chk("t1_err_cnt", 32'(err_seen), 32'd0);
        chk("t1_dout_cnt", 32'(dout_cnt), 32'd0);

        // 2: partial frame of 5 bits
        send_bits(16'h16, 5);
        drive_run(1'b0, 26);
        chk("t2_data", 32'(bus.data), 32'hA5);
        chk("t2_rdy_cnt", 32'(rdy_seen), 32'd1);
        chk("t2_err_cnt", 32'(err_seen), 32'd1);

        // 3: frame 0x3C plus four forwarded bits 1,0,1,1
        send_bits({4'h0, 8'h3C, 4'b1011}, 12);
        drive_run(1'b0, 26);
        chk("t3_data", 32'(bus.data), 32'h3C);
        chk("t3_rdy_cnt", 32'(rdy_seen), 32'd2);
        chk("t3_dout_pulses", 32'(dout_pulses), 32'd4);
        chk("t3_dout_cnt", 32'(dout_cnt), 32'd20);

        // 4: over-long high mid-frame, 0xFF ignored until resync, then 0x81
        send_bits(16'h5, 3);
        drive_run(1'b1, 16);
        drive_run(1'b0, 4);
        send_bits(16'hFF, 8);
        drive_run(1'b0, 20);
        send_bits(16'h81, 8);
        drive_run(1'b0, 26);
        chk("t4_data", 32'(bus.data), 32'h81);
        chk("t4_rdy_cnt", 32'(rdy_seen), 32'd3);
        chk("t4_err_cnt", 32'(err_seen), 32'd2);

        // 5: reset after 4 bits, then full 0x0F frame
        send_bits(16'hA, 4);
        do_reset();
        drive_run(1'b0, 20);
        send_bits(16'h0F, 8);
        drive_run(1'b0, 26);
        chk("t5_data", 32'(bus.data), 32'h0F);
        chk("t5_err_cnt", 32'(err_seen), 32'd2);

        // 6: widths 3/4 at threshold, gap 19 inside frame, gap 20 then immediate next frame
        for (int i = 0; i < 8; i++) send_bit(hi6[i] >= THRESH, hi6[i], lo6[i]);
        send_bits(16'h5A, 8);
        drive_run(1'b0, 26);
        chk("t6_rdy_cnt", 32'(rdy_seen), 32'd6);
        if (rdy_hist.size() >= 6) begin
            chk("t6_boundary_frame", 32'(rdy_hist[4]), 32'hB2);
            chk("t6_next_frame", 32'(rdy_hist[5]), 32'h5A);
        end else begin
            chk("t6_hist_len", 32'(rdy_hist.size()), 32'd6);
        end
        chk("t6_err_cnt", 32'(err_seen), 32'd2);

        // Random frames: varying lengths, widths and gaps, one error injection
        for (int f = 0; f < 10; f++) begin
            int nb;
            if (f == 4) begin
                drive_run(1'b1, $urandom_range(HMAX, HMAX + 4));
                drive_run(1'b0, $urandom_range(TRST, TRST + 5));
            end
            nb = $urandom_range(N - 2, N + 3);
            for (int i = 0; i < nb; i++) begin
                bit b;
                b = 1'($urandom_range(0, 1));
                send_bit(b, b ? $urandom_range(THRESH, HMAX - 1) : $urandom_range(1, THRESH - 1),
                         $urandom_range(1, TRST - 1));
            end
            drive_run(1'b0, $urandom_range(TRST, TRST + 6));
        end
        drive_run(1'b0, 8);

        chk("end_data_q_empty", 32'(exp_q.size()), 32'd0);
        chk("end_dout_q_empty", 32'(exp_dout_q.size()), 32'd0);
        chk("end_err_cnt", 32'(err_seen), 32'(err_exp));
        chk("end_dout_cnt", 32'(dout_cnt), 32'(exp_dout_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
